uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a
// single-entry output register and valid/ready handshake.
//
// Optional feature macro: UART_RX_PARITY_EN. When defined, an even parity bit
// follows the data bits and parity_err reports a mismatch. When undefined,
// parity_err is tied low.
//
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   asynchronous active-low reset
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  received byte
//   rx_valid    out  rx_data holds an unconsumed byte
//   rx_ready    in   consumer accepts the byte this cycle
//   frame_err   out  stop bit of the held byte sampled low
//   parity_err  out  parity mismatch on the held byte
//   overrun     out  a completed byte was dropped (sticky until handshake)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 216
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       sync_q;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr_q, perr_d;
`endif

  logic rx_s_c;
  logic complete_c;
  logic handshake_c;

  assign rx_s_c      = sync_q[1];
  assign handshake_c = valid_q && rx_ready;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state: frame sequencing, then output register update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    complete_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_d     = perr_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_c) begin
          state_d = START;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches on the line.
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_c;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s_c ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Return to IDLE mid-stop-bit so a following start edge is caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          complete_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Handshake empties the output register and clears all flags.
    if (handshake_c) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end

    // A completed frame loads if the register is free or being drained this
    // cycle; otherwise it is dropped and overrun is flagged.
    if (complete_c) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = ~rx_s_c;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_bad_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at the default bit period.
// Received bytes are checked against a queue of expected results pushed when
// each frame is driven; frame variants come from a vector table, and the
// latency, glitch, overrun, same-cycle handshake and reset cases are
// hand-written sequences.
module tb_uart_rx;

  localparam int BIT = 217;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int LAT = 2281;
`else
  localparam bit PAR = 1'b0;
  localparam int LAT = 2064;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic vprev;

  uart_rx dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each new byte (rising rx_valid) is compared against the queue.
  always @(negedge clock) begin
    if (reset && rx_valid && !vprev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(rx_data), 32'(e.data));
        check("sb_ferr", 32'(frame_err), 32'(e.ferr));
        check("sb_perr", 32'(parity_err), 32'(e.perr));
      end
    end
    vprev <= rx_valid;
  end

  // Drive one frame from a post-edge time; cut>0 abandons it after cut cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int cut);
    logic [10:0] bits;
    int          nb;
    bits = PAR ? {stop, par, d, 1'b0} : {1'b0, stop, d, 1'b0};
    nb   = PAR ? 11 : 10;
    for (int c = 0; c < nb * BIT; c++) begin
      if (cut != 0 && c == cut) return;
      rx = bits[c / BIT];
      @(posedge clock);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, ^d, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    e.perr = PAR ? pe : 1'b0;
    sb.push_back(e);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{data: 8'h3C, stop: 1'b0, par: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
    tbl[1] = '{data: 8'h00, stop: 1'b1, par: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    tbl[2] = '{data: 8'hFF, stop: 1'b1, par: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    tbl[3] = '{data: 8'h5A, stop: 1'b0, par: 1'b1, exp_ferr: 1'b1, exp_perr: 1'b1};
    tbl[4] = '{data: 8'h81, stop: 1'b1, par: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
    tbl[5] = '{data: 8'h07, stop: 1'b1, par: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b1};
    tbl[6] = '{data: 8'h07, stop: 1'b1, par: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};
    tbl[7] = '{data: 8'h80, stop: 1'b1, par: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b0};

    n_checks = 0;
    n_fail   = 0;
    vprev    = 1'b0;
    reset    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;

    // Reset values.
    #2;
    check("rst_valid", 32'(rx_valid), 32'(0));
    check("rst_data", 32'(rx_data), 32'(0));
    check("rst_flags", 32'({frame_err, parity_err, overrun}), 32'(0));
    idle(3);
    reset = 1'b1;
    idle(5);
    check("post_rst_valid", 32'(rx_valid), 32'(0));

    // Ready while empty has no effect.
    consume();
    check("ready_empty", 32'(rx_valid), 32'(0));

    // First-byte latency and handshake.
    push(8'hA5, 1'b0, 1'b0);
    fork
      send_good(8'hA5);
      begin
        repeat (LAT) @(posedge clock);
        #1;
        check("lat_before", 32'(rx_valid), 32'(0));
        @(posedge clock);
        #1;
        check("lat_after", 32'(rx_valid), 32'(1));
      end
    join
    idle(300);
    check("hold_valid", 32'(rx_valid), 32'(1));
    check("hold_data", 32'(rx_data), 32'(8'hA5));
    consume();
    check("hs_valid", 32'(rx_valid), 32'(0));

    // Short low pulse is rejected.
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(400);
    check("glitch_valid", 32'(rx_valid), 32'(0));

    // Table of frame variants.
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].data, tbl[i].exp_ferr, tbl[i].exp_perr);
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].par, 0);
      idle(300);
      check("tbl_valid", 32'(rx_valid), 32'(1));
      check("tbl_ferr", 32'(frame_err), 32'(tbl[i].exp_ferr));
      consume();
      check("tbl_hs_valid", 32'(rx_valid), 32'(0));
      check("tbl_hs_flags", 32'({frame_err, parity_err}), 32'(0));
    end

    // Back-to-back frames with no consumer: second byte dropped.
    push(8'h11, 1'b0, 1'b0);
    send_good(8'h11);
    send_good(8'h22);
    idle(300);
    check("ovr_data", 32'(rx_data), 32'(8'h11));
    check("ovr_flag", 32'(overrun), 32'(1));
    check("ovr_valid", 32'(rx_valid), 32'(1));

    // Handshake on the completion edge: new byte replaces held one.
    fork
      send_good(8'h33);
      begin
        repeat (LAT) @(posedge clock);
        #1;
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_ready = 1'b0;
        check("same_valid", 32'(rx_valid), 32'(1));
        check("same_data", 32'(rx_data), 32'(8'h33));
        check("same_ovr", 32'(overrun), 32'(0));
      end
    join
    idle(300);
    consume();
    check("same_hs_valid", 32'(rx_valid), 32'(0));

    // Overrun cleared by a plain handshake.
    push(8'h44, 1'b0, 1'b0);
    send_good(8'h44);
    send_good(8'h55);
    idle(300);
    check("ovr2_data", 32'(rx_data), 32'(8'h44));
    check("ovr2_flag", 32'(overrun), 32'(1));
    consume();
    check("ovr2_clr", 32'({rx_valid, overrun}), 32'(0));

    // Reset mid-frame with a flagged byte held.
    push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    idle(300);
    check("pre_rst_ferr", 32'(frame_err), 32'(1));
    send_frame(8'h55, 1'b1, ^8'h55, 1000);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 32'(0));
    check("mid_rst_data", 32'(rx_data), 32'(0));
    check("mid_rst_flags", 32'({frame_err, parity_err, overrun}), 32'(0));
    rx = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(300);
    check("partial_lost", 32'(rx_valid), 32'(0));
    push(8'h66, 1'b0, 1'b0);
    send_good(8'h66);
    idle(300);
    check("after_rst_valid", 32'(rx_valid), 32'(1));
    check("after_rst_data", 32'(rx_data), 32'(8'h66));
    consume();

    idle(10);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
